irda_nec_transmitter: RTL and testbench

//   NEC-protocol infrared transmitter driving IRDA_TXD; the transmit-side counterpart of the board's IR receive path.

---
 rtl/irda_nec_pkg.sv | 15 +
 rtl/irda_carrier_gen.sv | 30 +++
 rtl/irda_nec_transmitter.sv | 130 +++++++++++++
 tb/tb_irda_nec_transmitter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/irda_nec_pkg.sv
// irda_nec_pkg: NEC transmitter state encoding and protocol timing in units.
package irda_nec_pkg;
    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, REP_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
    } state_t;
    localparam int LEAD_MARK_UNITS  = 16;
    localparam int LEAD_SPACE_UNITS = 8;
    localparam int REP_SPACE_UNITS  = 4;
    localparam int ZERO_SPACE_UNITS = 1;
    localparam int ONE_SPACE_UNITS  = 3;
    localparam int FRAME_BITS       = 32;
    function automatic logic is_mark(input state_t s);
        return s == LEAD_MARK || s == BIT_MARK || s == STOP_MARK;
    endfunction
endpackage

// File: rtl/irda_carrier_gen.sv
// irda_carrier_gen: square-wave carrier phase, HALF clocks per level, restartable at phase high.
module irda_carrier_gen #(
    parameter int HALF = 657
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic phase
);
    localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          wrap;
    assign wrap = cnt_q == CW'(HALF - 1);
    always_comb begin
        cnt_d   = restart ? '0   : enable ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        phase_d = restart ? 1'b1 : (enable && wrap) ? ~phase_q : phase_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end
    assign phase = phase_q;
endmodule

// File: rtl/irda_nec_transmitter.sv
// irda_nec_transmitter: NEC IR frame transmitter driving IRDA_TXD with a modulated carrier.
// Define IRDA_REPEAT_EN to add tx_repeat and the NEC repeat-code sequence.
module irda_nec_transmitter
    import irda_nec_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int CARRIER_HZ  = 38_000,
    parameter int UNIT_CYCLES = 28_125,
    parameter int GAP_UNITS   = 72
) (
    input  logic       CLOCK_50,
    input  logic       reset,
`ifdef IRDA_REPEAT_EN
    input  logic       tx_repeat,
`endif
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    output logic       busy,
    output logic       IRDA_TXD
);
    localparam int HALF      = CLK_FREQ_HZ / (2 * CARRIER_HZ);
    localparam int MAX_UNITS = GAP_UNITS > LEAD_MARK_UNITS ? GAP_UNITS : LEAD_MARK_UNITS;
    localparam int UW        = UNIT_CYCLES > 1 ? $clog2(UNIT_CYCLES) : 1;
    localparam int NW        = MAX_UNITS > 1 ? $clog2(MAX_UNITS) : 1;

    state_t        state_q, state_d;
    logic [UW-1:0] cyc_q, cyc_d;
    logic [NW-1:0] units_q, units_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   shift_q, shift_d;
    logic          busy_q, busy_d, txd_q, txd_d;
    logic          unit_end, state_end, entering, phase;
    int            dur;
`ifdef IRDA_REPEAT_EN
    logic          rep_q, rep_d;
`endif

    assign tx_ready = state_q == IDLE;
    assign busy     = busy_q;
    assign IRDA_TXD = txd_q;
    assign unit_end  = cyc_q == UW'(UNIT_CYCLES - 1);
    assign state_end = unit_end && units_q == NW'(dur - 1);
    assign entering  = state_d != state_q;

    always_comb begin
        dur = state_q == LEAD_MARK  ? LEAD_MARK_UNITS  :
              state_q == LEAD_SPACE ? LEAD_SPACE_UNITS :
              state_q == REP_SPACE  ? REP_SPACE_UNITS  :
              state_q == BIT_SPACE  ? (shift_q[0] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS) :
              state_q == GAP        ? GAP_UNITS : 1;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
`ifdef IRDA_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (state_q == IDLE) begin
            if (tx_valid) begin
                state_d = LEAD_MARK;
                shift_d = {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                bit_d   = '0;
`ifdef IRDA_REPEAT_EN
                rep_d   = tx_repeat;
`endif
            end
        end else if (state_end) begin
            case (state_q)
`ifdef IRDA_REPEAT_EN
                LEAD_MARK:  state_d = rep_q ? REP_SPACE : LEAD_SPACE;
                REP_SPACE:  state_d = STOP_MARK;
`else
                LEAD_MARK:  state_d = LEAD_SPACE;
`endif
                LEAD_SPACE: state_d = BIT_MARK;
                BIT_MARK:   state_d = BIT_SPACE;
                BIT_SPACE: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    state_d = bit_q == 5'(FRAME_BITS - 1) ? STOP_MARK : BIT_MARK;
                end
                STOP_MARK:  state_d = GAP;
                default:    state_d = IDLE;
            endcase
        end
        // Timing counters restart on every state entry and stay cleared while idle.
        cyc_d   = (entering || state_q == IDLE || unit_end) ? '0 : cyc_q + 1'b1;
        units_d = (entering || state_q == IDLE) ? '0 : unit_end ? units_q + 1'b1 : units_q;
        busy_d  = state_d != IDLE;
        txd_d   = is_mark(state_q) && phase;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            units_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            txd_q   <= 1'b0;
`ifdef IRDA_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            units_q <= units_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
`ifdef IRDA_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    irda_carrier_gen #(.HALF(HALF)) u_carrier (
        .clk     (CLOCK_50),
        .rst     (reset),
        .restart (is_mark(state_d) && entering),
        .enable  (is_mark(state_q)),
        .phase   (phase)
    );
endmodule

// File: tb/tb_irda_nec_transmitter.sv
// tb_irda_nec_transmitter: randomized frames checked against a unit-level NEC waveform model and a space-width decoder.
module tb_irda_nec_transmitter;
    localparam int UNIT = 8;
    localparam int HALF = 2;
    localparam int GAP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_addr = '0;
    logic [7:0] tx_cmd = '0;
    logic       tx_ready, busy, txd;
`ifdef IRDA_REPEAT_EN
    logic       tx_repeat = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    bit wave[$];
    bit samp[$];

    always #5 clk = ~clk;

    irda_nec_transmitter #(
        .CLK_FREQ_HZ(50_000_000), .CARRIER_HZ(12_500_000), .UNIT_CYCLES(UNIT), .GAP_UNITS(GAP)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
`ifdef IRDA_REPEAT_EN
        .tx_repeat(tx_repeat),
`endif
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_addr  (tx_addr),
        .tx_cmd   (tx_cmd),
        .busy     (busy),
        .IRDA_TXD (txd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add(input bit mark, input int units);
        for (int j = 0; j < units * UNIT; j++) wave.push_back(mark && ((j / HALF) % 2 == 0));
    endtask

    // Expected IRDA_TXD per clock for one frame, from the protocol's unit durations.
    task automatic build(input logic [7:0] a, input logic [7:0] c, input bit rep);
        logic [31:0] w;
        w = {~c, c, ~a, a};
        wave = {};
        add(1, 16);
        if (rep) add(0, 4);
        else begin
            add(0, 8);
            for (int i = 0; i < 32; i++) begin
                add(1, 1);
                add(0, w[i] ? 3 : 1);
            end
        end
        add(1, 1);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input bit rep, input bit hold, input int abort);
        int n, low;
        int runs[$];
        logic [31:0] dec;
        build(a, c, rep);
        n = wave.size();
        tx_addr  = a;
        tx_cmd   = c;
        tx_valid = 1'b1;
`ifdef IRDA_REPEAT_EN
        tx_repeat = rep;
`endif
        check("ready_before_accept", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
        samp = {};
        for (int k = 0; k < n + GAP * UNIT; k++) begin
            if (k > 0) @(negedge clk);
            check("busy", busy, 1);
            check("ready_low", tx_ready, 0);
            check("txd", txd, (k >= 1 && k <= n) ? 32'(wave[k-1]) : 32'd0);
            if (k >= 1 && k <= n) samp.push_back(txd);
            tx_addr = 8'($urandom);
            tx_cmd  = 8'($urandom);
            if (k == abort) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_txd", txd, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", tx_ready, 1);
                reset = 1'b0;
                return;
            end
        end
        @(negedge clk);
        check("end_busy", busy, 0);
        check("end_ready", tx_ready, 1);
        check("end_txd", txd, 0);
        low = 0;
        foreach (samp[i]) begin
            if (!samp[i]) low++;
            else begin
                if (low >= UNIT) runs.push_back(low);
                low = 0;
            end
        end
        if (rep) begin
            check("rep_runs", runs.size(), 1);
            if (runs.size() == 1) check("rep_space_units", runs[0] / UNIT, 4);
        end else begin
            check("space_count", runs.size(), 33);
            dec = '0;
            if (runs.size() == 33) begin
                check("lead_space_units", runs[0] / UNIT, 8);
                for (int i = 0; i < 32; i++) dec[i] = (runs[i+1] / UNIT) >= 2;
            end
            check("dec_addr", dec[7:0], a);
            check("dec_naddr", dec[15:8], 8'(~a));
            check("dec_cmd", dec[23:16], c);
            check("dec_ncmd", dec[31:24], 8'(~c));
        end
    endtask

    initial begin
        logic [7:0] a, c;
        logic [31:0] w;
        int st;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_txd", txd, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", tx_ready, 1);
        end
        run_frame(8'h00, 8'hFF, 0, 0, -1);
        run_frame(8'hA5, 8'h3C, 0, 1, -1);
        run_frame(8'($urandom), 8'($urandom), 0, 0, -1);
        a = 8'($urandom);
        c = 8'($urandom);
        w = {~c, c, ~a, a};
        st = 24;
        for (int i = 0; i < 10; i++) st += 1 + (w[i] ? 3 : 1);
        st += 1;
        run_frame(a, c, 0, 0, st * UNIT + 3);
        for (int i = 0; i < 3; i++) run_frame(8'($urandom), 8'($urandom), 0, 0, -1);
`ifdef IRDA_REPEAT_EN
        run_frame(8'($urandom), 8'($urandom), 1, 0, -1);
        run_frame(8'($urandom), 8'($urandom), 0, 0, -1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
